bcd_score_to_bin: RTL and testbench

- Sequential decimal-to-binary converter; the inverse of the score-to-digit path.
- Accepts a score entered as packed BCD digits (menu/score-preset entry, persisted high scores) and returns the binary score value for the game logic score registers.
- Uses the reverse double-dabble algorithm, one bit per clock, with a start/busy/done handshake and an error flag for invalid digits or overflow.

---
 rtl/bcd_score_to_bin_if.sv | 23 ++
 rtl/bcd_score_to_bin.sv | 145 ++++++++++++++
 tb/tb_bcd_score_to_bin.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_score_to_bin_if.sv
// Handshake bundle for the BCD score to binary converter.
// The master issues start/bcd_in; the slave answers with busy/done/bin_out/err.
interface bcd_score_to_bin_if #(
  parameter int NDIG  = 3,
  parameter int OUT_W = 10
);
  logic                start;
  logic [4*NDIG-1:0]   bcd_in;
  logic                busy;
  logic                done;
  logic [OUT_W-1:0]    bin_out;
  logic                err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_score_to_bin.sv
// Packed BCD score to binary converter using reverse double-dabble, one bit per clock.
// Results saturate when the decimal value exceeds the binary score width; bad digits flag err.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; a start captures bcd_in
// SHIFT | one right shift plus per-digit correction per cycle
// DONE  | one-cycle done pulse; start here chains the next conversion
module bcd_score_to_bin #(
  parameter int NDIG  = 3,
  parameter int OUT_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  bcd_score_to_bin_if.slave   bus
);

  localparam int ACC_W = 4 * NDIG;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [ACC_W-1:0]    bcd_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                invalid_q;
  logic [OUT_W-1:0]    bin_q;
  logic                err_q;

  logic                accept;
  logic                last_shift;
  logic                invalid_in;
  logic [2*ACC_W-1:0]  pair_shift;
  logic [ACC_W-1:0]    bcd_next;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W+OUT_W-1:0] acc_ext;
  logic                overflow;
  logic                busy_o;
  logic                done_o;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == LAST_CNT) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_SHIFT: busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  assign accept     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

  always_comb begin
    invalid_in = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9) invalid_in = 1'b1;
    end
  end

  // Shift the BCD/binary pair right, then pull back any digit that picked up
  // a borrowed 8 from the digit above (8 in the next-lower decade is 5, so -3).
  always_comb begin
    pair_shift = {bcd_q, acc_q} >> 1;
    bcd_next   = pair_shift[2*ACC_W-1:ACC_W];
    acc_next   = pair_shift[ACC_W-1:0];
    for (int d = 0; d < NDIG; d++) begin
      if (bcd_next[4*d+3]) bcd_next[4*d +: 4] = bcd_next[4*d +: 4] - 4'd3;
    end
  end

  assign acc_ext  = {{OUT_W{1'b0}}, acc_next};
  assign overflow = |acc_ext[ACC_W+OUT_W-1:OUT_W];

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      invalid_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      bcd_q     <= bus.bcd_in;
      acc_q     <= '0;
      cnt_q     <= '0;
      invalid_q <= invalid_in;
    end else if (state_q == S_SHIFT) begin
      bcd_q <= bcd_next;
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_shift) begin
        if (invalid_q) begin
          bin_q <= '0;
          err_q <= 1'b1;
        end else if (overflow) begin
          bin_q <= '1;
          err_q <= 1'b1;
        end else begin
          bin_q <= acc_ext[OUT_W-1:0];
          err_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy    = busy_o;
  assign bus.done    = done_o;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_score_to_bin.sv
// Directed bench for bcd_score_to_bin: a 3-digit and a 4-digit instance share clock and reset.
module tb_bcd_score_to_bin;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bcd_score_to_bin_if #(.NDIG(3), .OUT_W(10)) if3 ();
  bcd_score_to_bin_if #(.NDIG(4), .OUT_W(10)) if4 ();

  bcd_score_to_bin #(.NDIG(3), .OUT_W(10)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave)
  );

  bcd_score_to_bin #(.NDIG(4), .OUT_W(10)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start on one instance and wait for done; leaves the bench in the done cycle.
  task automatic convert(input bit use4, input logic [15:0] bcd,
                         output int busy_cycles, output bit got_done,
                         output logic [9:0] bin, output logic e);
    if (use4) begin
      if4.bcd_in = bcd;
      if4.start  = 1'b1;
    end else begin
      if3.bcd_in = bcd[11:0];
      if3.start  = 1'b1;
    end
    @(negedge clk);
    if3.start   = 1'b0;
    if4.start   = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    bin         = '0;
    e           = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (use4 ? if4.done : if3.done) begin
        got_done = 1'b1;
        bin      = use4 ? if4.bin_out : if3.bin_out;
        e        = use4 ? if4.err : if3.err;
        break;
      end
      if (use4 ? if4.busy : if3.busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    if3.start  = 1'b0;
    if3.bcd_in = '0;
    if4.start  = 1'b0;
    if4.bcd_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({if3.busy, if3.done, if3.err} !== 3'b000) begin
      failures++;
      $display("FAIL reset3_flags got busy/done/err=%b expected 000", {if3.busy, if3.done, if3.err});
    end
    checks++;
    if (if3.bin_out !== 10'd0) begin
      failures++;
      $display("FAIL reset3_bin got %0d expected 0", if3.bin_out);
    end
    checks++;
    if ({if4.busy, if4.done, if4.err, if4.bin_out} !== 13'd0) begin
      failures++;
      $display("FAIL reset4_state got %b expected all zero", {if4.busy, if4.done, if4.err, if4.bin_out});
    end
  endtask

  task automatic test_basic;
    int n; bit d; logic [9:0] b; logic e;
    convert(1'b0, 16'h042, n, d, b, e);
    checks++;
    if (!d || n != 12) begin
      failures++;
      $display("FAIL basic_latency got done=%0d busy_cycles=%0d expected done=1 busy_cycles=12", d, n);
    end
    checks++;
    if (b !== 10'd42 || e !== 1'b0) begin
      failures++;
      $display("FAIL basic_042 got bin=%0d err=%b expected bin=42 err=0", b, e);
    end
    @(negedge clk);
    checks++;
    if (if3.done !== 1'b0 || if3.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b busy=%b expected 0 0", if3.done, if3.busy);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (if3.bin_out !== 10'd42 || if3.err !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got bin=%0d err=%b expected bin=42 err=0", if3.bin_out, if3.err);
    end
  endtask

  task automatic test_values;
    logic [15:0] vin  [5] = '{16'h999, 16'h000, 16'h1A3, 16'h512, 16'h0F0};
    logic [9:0]  vbin [5] = '{10'd999, 10'd0,   10'd0,   10'd512, 10'd0};
    logic        verr [5] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1};
    int n; bit d; logic [9:0] b; logic e;
    for (int k = 0; k < 5; k++) begin
      convert(1'b0, vin[k], n, d, b, e);
      @(negedge clk);
      checks++;
      if (!d || n != 12 || b !== vbin[k] || e !== verr[k]) begin
        failures++;
        $display("FAIL values3_%h got done=%0d cycles=%0d bin=%0d err=%b expected done=1 cycles=12 bin=%0d err=%b",
                 vin[k][11:0], d, n, b, e, vbin[k], verr[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n; int dones; bit d; logic [9:0] b; logic e;
    if3.bcd_in = 12'h123;
    if3.start  = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (4) @(negedge clk);
    // fifth SHIFT cycle: this start and new digits must be ignored
    if3.bcd_in = 12'h456;
    if3.start  = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    n = 0;
    d = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if3.done) begin
        d = 1'b1;
        break;
      end
      if (if3.busy) n++;
      @(negedge clk);
    end
    checks++;
    if (!d || n != 7 || if3.bin_out !== 10'd123 || if3.err !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore got done=%0d remaining=%0d bin=%0d err=%b expected done=1 remaining=7 bin=123 err=0",
               d, n, if3.bin_out, if3.err);
    end
    // start during the done cycle chains directly into the next conversion
    convert(1'b0, 16'h456, n, d, b, e);
    checks++;
    if (!d || n != 12 || b !== 10'd456 || e !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back got done=%0d cycles=%0d bin=%0d err=%b expected done=1 cycles=12 bin=456 err=0",
               d, n, b, e);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if3.done) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL no_queued_start got %0d extra done pulses expected 0", dones);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    if3.bcd_in = 12'h777;
    if3.start  = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({if3.busy, if3.done, if3.err, if3.bin_out} !== 13'd0) begin
      failures++;
      $display("FAIL reset_abort got busy/done/err/bin=%b expected all zero",
               {if3.busy, if3.done, if3.err, if3.bin_out});
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if3.done || if3.busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_no_done got %0d busy/done cycles after release expected 0", dones);
    end
  endtask

  task automatic test_ndig4;
    logic [15:0] vin  [5] = '{16'h1234, 16'h1023, 16'h9999, 16'h1024, 16'hF000};
    logic [9:0]  vbin [5] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd0};
    logic        verr [5] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1};
    int n; bit d; logic [9:0] b; logic e;
    for (int k = 0; k < 5; k++) begin
      convert(1'b1, vin[k], n, d, b, e);
      @(negedge clk);
      checks++;
      if (!d || n != 16 || b !== vbin[k] || e !== verr[k]) begin
        failures++;
        $display("FAIL ndig4_%h got done=%0d cycles=%0d bin=%0d err=%b expected done=1 cycles=16 bin=%0d err=%b",
                 vin[k], d, n, b, e, vbin[k], verr[k]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_reset_abort();
    test_ndig4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
